// File: rtl/puf_challenge_driver.sv
// puf_challenge_driver: initiator for the 64-stage arbiter PUF array.
// Drives a challenge (external or from an internal Galois LFSR) on puf_c,
// launches puf_s REPS times with SETTLE-cycle settle phases, samples puf_q
// once per launch and majority-votes the samples. The result is returned
// over a valid/ready handshake.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, use_lfsr   : evaluation request and challenge source select
//   chal_in           : external challenge
//   seed_load, seed   : LFSR seed load (zero seed loads 64'h1)
//   puf_s, puf_c      : PUF launch line and challenge bus (registered)
//   puf_q             : PUF response bus
//   resp, resp_chal, resp_unstable, resp_valid : voted result (registered)
//   resp_ready        : consumer accepts result
//   busy              : evaluation in progress (registered)
module puf_challenge_driver #(
  parameter int unsigned SETTLE    = 8,
  parameter int unsigned REPS      = 7,
  parameter logic [63:0] LFSR_SEED = 64'hACE1_2468_1357_BDF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        use_lfsr,
  input  logic [63:0] chal_in,
  input  logic        seed_load,
  input  logic [63:0] seed,
  output logic        puf_s,
  output logic [63:0] puf_c,
  input  logic [63:0] puf_q,
  output logic [63:0] resp,
  output logic [63:0] resp_chal,
  output logic [63:0] resp_unstable,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        busy
);

  localparam int unsigned W  = 64;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = 8;
  localparam logic [W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FIRE,
    ST_SAMPLE,
    ST_VOTE,
    ST_DONE
  } state_t;

  state_t              state;
  logic [W-1:0][CW-1:0] cnt;
  logic [CW-1:0]       rep;
  logic [PW-1:0]       phase;
  logic [W-1:0]        lfsr;

  logic [W-1:0]        seed_val;
  logic [W-1:0]        lfsr_cur;
  logic [W-1:0]        lfsr_nxt;
  logic [W-1:0]        vote_resp;
  logic [W-1:0]        vote_unst;
  logic                phase_end;
  logic                last_rep;

  // Seed load takes effect before the LFSR value is used by a same-cycle start.
  always_comb begin
    seed_val = seed;
    if (seed == '0) seed_val = W'(1);
    lfsr_cur = seed_load ? seed_val : lfsr;
    lfsr_nxt = lfsr_cur >> 1;
    if (lfsr_cur[0]) lfsr_nxt = lfsr_nxt ^ LFSR_TAPS;
  end

  // Majority vote and disagreement mask from the per-bit one-counters.
  always_comb begin
    vote_resp = '0;
    vote_unst = '0;
    for (int i = 0; i < int'(W); i++) begin
      vote_resp[i] = (cnt[i] > CW'(REPS / 2));
      vote_unst[i] = (cnt[i] != '0) && (cnt[i] != CW'(REPS));
    end
  end

  assign phase_end = (phase == PW'(SETTLE - 1));
  assign last_rep  = (32'(rep) >= REPS - 1);

  // Sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rep           <= '0;
      phase         <= '0;
      lfsr          <= LFSR_SEED;
      puf_s         <= 1'b0;
      puf_c         <= '0;
      resp          <= '0;
      resp_chal     <= '0;
      resp_unstable <= '0;
      resp_valid    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            puf_c <= use_lfsr ? lfsr_cur : chal_in;
            lfsr  <= use_lfsr ? lfsr_nxt : lfsr_cur;
            cnt   <= '0;
            rep   <= '0;
            phase <= '0;
            busy  <= 1'b1;
            state <= ST_SETUP;
          end else begin
            lfsr <= lfsr_cur;
          end
        end
        ST_SETUP: begin
          if (phase_end) begin
            phase <= '0;
            puf_s <= 1'b1;
            state <= ST_FIRE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        ST_FIRE: begin
          if (phase_end) begin
            phase <= '0;
            state <= ST_SAMPLE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        ST_SAMPLE: begin
          for (int i = 0; i < int'(W); i++) begin
            cnt[i] <= cnt[i] + CW'(puf_q[i]);
          end
          puf_s <= 1'b0;
          if (last_rep) begin
            state <= ST_VOTE;
          end else begin
            rep   <= rep + CW'(1);
            state <= ST_SETUP;
          end
        end
        ST_VOTE: begin
          resp          <= vote_resp;
          resp_unstable <= vote_unst;
          resp_chal     <= puf_c;
          resp_valid    <= 1'b1;
          state         <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          puf_s      <= 1'b0;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/puf_challenge_driver.md
# puf_challenge_driver

Initiator side of the 64-stage arbiter PUF array. The block takes a challenge (external or from an internal 64-bit LFSR) and drives it on the PUF challenge bus. It launches the PUF start signal repeatedly, samples the 64-bit response once per launch, and majority-votes the samples. It returns the voted response, the challenge used, and a per-bit instability mask to a consumer over a valid/ready handshake.

## Interface
- `SETTLE`, default 8: cycles for each settle phase, s low before launch and s high before sample; legal 1..255.
- `REPS`, default 7: launches per challenge; odd; legal 1..15.
- `LFSR_SEED`, default 64'hACE1_2468_1357_BDF0: LFSR reset value; must be nonzero.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request one evaluation; accepted only in IDLE.
- `use_lfsr` in 1: sampled with `start`; 1 = LFSR challenge, 0 = `chal_in`.
- `chal_in` in 64: external challenge.
- `seed_load` in 1: load `seed` into LFSR; honoured only in IDLE.
- `seed` in 64: LFSR seed; 0 loads 64'h1.
- `puf_s` out 1: PUF start/launch line.
- `puf_c` out 64: PUF challenge bus.
- `puf_q` in 64: PUF response bus.
- `resp` out 64: majority-voted response.
- `resp_chal` out 64: challenge that produced `resp`.
- `resp_unstable` out 64: bit i = 1 if the REPS samples of bit i disagreed.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: consumer accepts result.
- `busy` out 1: state != IDLE.

## Operation
- States:
  - IDLE
  - SETUP: `puf_s`=0; `SETTLE` cycles.
  - FIRE: `puf_s`=1; `SETTLE` cycles.
  - SAMPLE: `puf_s`=1; 1 cycle; capture `puf_q`.
  - VOTE: 1 cycle.
  - DONE: hold result until the handshake.
- IDLE→SETUP on `start`.
  - Latch the challenge into `puf_c` (LFSR value if `use_lfsr`, else `chal_in`).
  - Clear the 64 per-bit 4-bit one-counters and the repetition counter.
  - If `use_lfsr`, advance the LFSR one step after using its current value.
- SETUP→FIRE and FIRE→SAMPLE after `SETTLE` cycles each, using an 8-bit phase counter.
- SAMPLE: for each bit, count[i] += puf_q[i].
  - Next state is SETUP if the repetition counter < REPS-1 (counter increments).
  - Otherwise next state is VOTE.
- VOTE computes:
  - resp[i] = (count[i] > REPS/2).
  - resp_unstable[i] = (count[i] != 0 && count[i] != REPS).
  - resp_chal = puf_c.
  - Next state DONE.
- DONE asserts `resp_valid`; `resp_valid && resp_ready` → IDLE, and `resp_valid` drops the next cycle.
- LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1, shifts right. When the output bit is 1, XOR with 64'hD800_0000_0000_0000.
- `puf_c` changes only on `start` acceptance. It is stable through all reps and stays at its last value afterwards.
- Boundary rules:
  - `start` outside IDLE: ignored, no queueing.
  - `start` in DONE while the handshake completes: ignored.
  - `start` and `seed_load` in the same IDLE cycle: the seed is loaded first, and the challenge is the loaded seed (0→64'h1) when `use_lfsr`=1.
  - `seed_load` outside IDLE: ignored.
  - REPS=1: the unstable mask is all zero.

## Timing
- Reset values:
  - State IDLE.
  - `puf_s`=0, `puf_c`=0, `resp`=0, `resp_chal`=0, `resp_unstable`=0.
  - `resp_valid`=0, `busy`=0.
  - LFSR = `LFSR_SEED`.
- Reset mid-operation aborts at once: `puf_s`=0 on the cycle after `rst`, counters cleared, no partial result emitted.
- All outputs are registered.
- `start` sampled at edge k:
  - `busy`=1 and `puf_c` valid after edge k.
  - `puf_s` rises after edge k+SETTLE and falls after edge k+2·SETTLE+1 for the first rep.
  - Rep r (0-based) samples `puf_q` at edge k+(r+1)(2·SETTLE+1).
  - `resp_valid`=1 after edge k+REPS(2·SETTLE+1)+1; default latency 120 cycles.
- `resp`, `resp_chal`, `resp_unstable` are stable while `resp_valid`=1, and hold until the next VOTE.
- Minimum spacing between accepted starts: latency + 2 cycles with `resp_ready` tied high.

## Test plan
- Reset, then `use_lfsr`=0, `chal_in`=64'h0123_4567_89AB_CDEF, `start`, constant `puf_q`=64'hFFFF_0000_FFFF_0000.
  - Required: `puf_c`=chal_in for the whole run.
  - Required: 7 `puf_s` high pulses of 9 cycles, 8 cycles low between them.
  - Required: `resp_valid` after 120 cycles, `resp`=64'hFFFF_0000_FFFF_0000, `resp_unstable`=0.
- Model bit 0 returns 1 on reps 0–3 and 0 on reps 4–6; bit 1 returns 1 on reps 0–2 only.
  - Required: resp[0]=1, resp[1]=0, resp_unstable[1:0]=2'b11.
- `seed_load` with `seed`=0 and `start`, `use_lfsr`=1 in the same cycle.
  - Required: `puf_c`=64'h1.
  - Required: the next `start` uses 64'hD800_0000_0000_0000.
- Hold `resp_ready`=0 for 20 cycles and pulse `start` during DONE.
  - Required: `resp_valid` and the result stay held, the `start` is ignored, and `busy`=1.
  - On `resp_ready`: `resp_valid` drops and state returns to IDLE.
- Assert `rst` during the 3rd FIRE.
  - Required: `puf_s`=0 and `busy`=0 the next cycle.
  - Required: no `resp_valid`; a subsequent `start` gives a correct full 120-cycle run.
- Pulse `seed_load` and `start` while busy.
  - Required: the LFSR and `puf_c` are unchanged, and no extra evaluation occurs.
